// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg -- shared definitions for the multi-port register file.
//   DEF_DATA_W : default register width in bits
//   DEF_ADDR_W : default address width (DEPTH = 2**ADDR_W)
//   state_t    : controller state encoding (CLEAR = 0, RUN = 1)
package reg_file_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_mp_wsel.sv
// reg_file_mp_wsel -- write-port priority resolver for one address.
// Reports whether any enabled write port targets addr and, if so, the data
// of the highest-index such port.
//   we   : per-port write enables
//   wa   : packed write addresses, slice k for port k
//   wd   : packed write data, slice k for port k
//   addr : address being resolved
//   hit  : some enabled port targets addr
//   data : winning port's write data (0 when no hit)
module reg_file_mp_wsel
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Ascending scan: a later (higher-index) match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && (wa[k*ADDR_W +: ADDR_W] == addr)) begin
        hit  = 1'b1;
        data = wd[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp -- multi-port register file with hardwired-zero entry 0 and a
// post-reset clear sweep.
//   clk     : clock, all state changes on rising edge
//   RESET_N : asynchronous active-low reset
//   WE      : write enables, bit k for write port k
//   WA / WD : packed write address / data, slice k for port k
//   RA / RD : packed read address / data, slice j for read port j (combinational)
//   READY   : high once the clear sweep has finished
// After reset the controller sits in CLEAR, zeroing entries 1..DEPTH-1 one
// per cycle; writes are ignored and reads return 0 until RUN is reached.
// Optional build macro REG_FILE_MP_BYPASS_EN: same-cycle write data is
// forwarded onto matching read ports in RUN.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     RESET_N,
  input  logic [NUM_WR-1:0]        WE,
  input  logic [NUM_WR*ADDR_W-1:0] WA,
  input  logic [NUM_WR*DATA_W-1:0] WD,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] RD,
  output logic                     READY
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_INIT = ADDR_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic                clr_en;
  logic                run_en;
  logic [DEPTH*DATA_W-1:0] entries;

  // Controller: state register
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) state <= CLEAR;
    else          state <= state_nxt;
  end

  // Controller: next state. Leave CLEAR on the edge that clears the last entry.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (cnt == CNT_LAST) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // Controller: outputs
  always_comb begin
    clr_en = (state == CLEAR);
    run_en = (state == RUN);
    READY  = run_en;
  end

  // Sweep counter starts at 1 because entry 0 needs no clearing; it wraps to
  // 0 together with the move to RUN and then stays put.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N)    cnt <= CNT_INIT;
    else if (clr_en) cnt <= cnt + ADDR_W'(1);
  end

  // Storage: one register per nonzero entry, each with its own priority
  // resolver so that multi-port collisions resolve to the highest port.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (i == 0) begin : g_zero
      assign entries[0 +: DATA_W] = '0;
    end else begin : g_reg
      logic              hit;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] q;

      reg_file_mp_wsel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
      ) u_wsel (
        .we   (WE),
        .wa   (WA),
        .wd   (WD),
        .addr (ADDR_W'(i)),
        .hit  (hit),
        .data (wdata)
      );

      always_ff @(posedge clk) begin
        if (clr_en) begin
          if (cnt == ADDR_W'(i)) q <= '0;
        end else if (hit) begin
          q <= wdata;
        end
      end

      assign entries[i*DATA_W +: DATA_W] = q;
    end
  end

  // Read ports: forced to 0 outside RUN.
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;

    assign ra     = RA[j*ADDR_W +: ADDR_W];
    assign stored = entries[ra*DATA_W +: DATA_W];

`ifdef REG_FILE_MP_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    reg_file_mp_wsel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_byp (
      .we   (WE),
      .wa   (WA),
      .wd   (WD),
      .addr (ra),
      .hit  (byp_hit),
      .data (byp_data)
    );

    // Address 0 never forwards: its writes are discarded.
    assign RD[j*DATA_W +: DATA_W] = !run_en ? '0 :
                                    (byp_hit && (ra != '0)) ? byp_data : stored;
`else
    assign RD[j*DATA_W +: DATA_W] = run_en ? stored : '0;
`endif
  end

endmodule
